// File: rtl/abro_input_conditioner.sv
// -----------------------------------------------------------------------------
// abro_input_conditioner
//
// Front-end for the ABRO state machine. Each raw button line is synchronised
// into the clk domain through two flops, debounced with a saturating counter,
// and turned into a single-cycle pulse on every debounced rising edge. The
// two channels (A, B) are identical and share no state.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive synchronised cycles an input must differ
//                     from its debounced level before the level flips (>= 1)
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   synchronous, active-high reset
//   a_raw   in   raw A button, asynchronous, may bounce
//   b_raw   in   raw B button, asynchronous, may bounce
//   A       out  one-cycle pulse on debounced rising edge of A
//   B       out  one-cycle pulse on debounced rising edge of B
//   a_level out  debounced level of A
//   b_level out  debounced level of B
// -----------------------------------------------------------------------------
module abro_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic a_level,
  output logic b_level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is channel A, bit 1 is channel B.
  logic [1:0]      raw;
  logic [1:0]      s1_q;
  logic [1:0]      s2_q;
  logic [1:0]      lvl_q;
  logic [1:0]      lvl_d;
  logic [1:0]      p_q;
  logic [1:0]      p_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];

  assign raw = {b_raw, a_raw};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i] = lvl_q[i];
      // Any agreement with the current level discards a partial count, so
      // glitches shorter than the window leave no trace.
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
      // Pulse only on a 0->1 level change; falling edges are silent.
      p_d[i] = ~lvl_q[i] & lvl_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      p_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      p_q   <= p_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign A       = p_q[0];
  assign B       = p_q[1];
  assign a_level = lvl_q[0];
  assign b_level = lvl_q[1];

endmodule
